// File: rtl/vga_frame_scheduler.sv
// VGA raster timing generator with a frame-buffer read strobe and a
// vblank-synchronised double-buffer swap handshake.
module vga_frame_scheduler #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk_25MHz,
  input  logic        reset_n,
  input  logic        swap_req,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        rd_en,
  output logic [18:0] rd_addr,
  output logic        frame_start,
  output logic        swap_ack,
  output logic        display_buf
);

  localparam int unsigned CW      = 10;
  localparam int unsigned AW      = 19;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_VIS_LAST = CW'(H_VISIBLE - 1);
  localparam logic [CW-1:0] V_VIS_LAST = CW'(V_VISIBLE - 1);
  localparam logic [CW-1:0] HS_START   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END     = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END     = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    ACK       = 2'd2,
    WAIT_DROP = 2'd3
  } swap_state_t;

  swap_state_t   state;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          rd_en_nxt;
  logic          last_read;
  logic          vblank_entry;

  // Next raster position, plus a look-ahead of one more pixel for the read strobe
  always_comb begin
    h_wrap       = (h_count == H_LAST);
    v_wrap       = (v_count == V_LAST);
    h_nxt        = h_wrap ? '0 : h_count + CW'(1);
    v_nxt        = v_count;
    rd_en_nxt    = 1'b0;
    last_read    = 1'b0;
    vblank_entry = h_wrap && (v_count == V_VIS_LAST);
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_count + CW'(1);
    end
    if (h_nxt == H_LAST) begin
      rd_en_nxt = (v_nxt == V_LAST) || (v_nxt < V_VIS_LAST);
    end else begin
      rd_en_nxt = (h_nxt < H_VIS_LAST) && (v_nxt < V_VIS_END);
    end
    last_read = rd_en && (h_nxt == H_VIS_LAST) && (v_nxt == V_VIS_LAST);
  end

  assign hsync       = !((h_count >= HS_START) && (h_count < HS_END));
  assign vsync       = !((v_count >= VS_START) && (v_count < VS_END));
  assign video_on    = (h_count < H_VIS_END) && (v_count < V_VIS_END);
  assign frame_start = (h_count == '0) && (v_count == '0);

  // Raster counters and read address; the address wraps after the frame's last read
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      h_count <= h_nxt;
      v_count <= v_nxt;
      rd_en   <= rd_en_nxt;
      if (rd_en) begin
        rd_addr <= last_read ? '0 : rd_addr + AW'(1);
      end
    end
  end

  // Swap handshake: latch a request, swap at vblank entry, wait for the request to drop
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      swap_ack    <= 1'b0;
      display_buf <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (swap_req) state <= PENDING;
        end
        PENDING: begin
          if (vblank_entry) begin
            state       <= ACK;
            swap_ack    <= 1'b1;
            display_buf <= ~display_buf;
          end
        end
        ACK: begin
          state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!swap_req) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
